// File: rtl/lsq_age_tracker_pkg.sv
// Shared sizing defaults and the per-entry record for the load/store age tracker.
package lsq_age_tracker_pkg;

    localparam int unsigned LSQ_DEPTH  = 32;
    localparam int unsigned LSQ_PTR_W  = $clog2(LSQ_DEPTH);
    localparam int unsigned LSQ_ADDR_W = 32;

    // One queue slot: ordering flags plus the resolved address.
    typedef struct packed {
        logic                  valid;
        logic                  is_store;
        logic                  addr_valid;
        logic [LSQ_ADDR_W-1:0] addr;
    } lsq_entry_t;

    // Head/tail pointers carry one extra wrap bit above the entry index.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lsq_age_tracker_if.sv
// Request/response bundle between the memory pipeline and the age tracker.
interface lsq_age_tracker_if
    import lsq_age_tracker_pkg::*;
#(
    parameter int unsigned DEPTH  = LSQ_DEPTH,
    parameter int unsigned ADDR_W = LSQ_ADDR_W
) ();

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic              alloc_valid;
    logic              alloc_is_store;
    logic              alloc_ready;
    logic [PTR_W-1:0]  alloc_entry;
    logic              addr_valid;
    logic [PTR_W-1:0]  addr_entry;
    logic [ADDR_W-1:0] addr;
    logic              commit_valid;
    logic [PTR_W-1:0]  commit_entry;
    logic              flush_valid;
    logic [PTR_W-1:0]  flush_entry;
    logic              query_valid;
    logic [PTR_W-1:0]  query_entry;
    logic              result_valid;
    logic [DEPTH-1:0]  older_mask;
    logic              older_store_unresolved;
    logic              older_store_match;
    logic [PTR_W:0]    count;
    logic              empty;

    // Pipeline side: issues requests, consumes status and query results.
    modport master (
        output alloc_valid, alloc_is_store, addr_valid, addr_entry, addr,
               commit_valid, flush_valid, flush_entry, query_valid, query_entry,
        input  alloc_ready, alloc_entry, commit_entry, result_valid, older_mask,
               older_store_unresolved, older_store_match, count, empty
    );

    // Tracker side.
    modport slave (
        input  alloc_valid, alloc_is_store, addr_valid, addr_entry, addr,
               commit_valid, flush_valid, flush_entry, query_valid, query_entry,
        output alloc_ready, alloc_entry, commit_entry, result_valid, older_mask,
               older_store_unresolved, older_store_match, count, empty
    );

endinterface

// File: rtl/lsq_age_tracker_age_compare.sv
// Head-relative age comparison for a single queue slot.
module lsq_age_tracker_age_compare
    import lsq_age_tracker_pkg::*;
#(
    parameter int unsigned PTR_W = LSQ_PTR_W
) (
    input  logic [PTR_W-1:0] head_idx,
    input  logic [PTR_W-1:0] entry_idx,
    input  logic [PTR_W-1:0] query_idx,
    input  logic             entry_valid,
    output logic             older
);

    logic [PTR_W-1:0] entry_rel;
    logic [PTR_W-1:0] query_rel;

    // Distances from head wrap naturally modulo DEPTH at PTR_W bits.
    assign entry_rel = entry_idx - head_idx;
    assign query_rel = query_idx - head_idx;
    assign older     = entry_valid && (entry_rel < query_rel);

endmodule

// File: rtl/lsq_age_tracker.sv
// Age-ordered load/store queue with wrap-bit pointers, flush and older-store query.
module lsq_age_tracker
    import lsq_age_tracker_pkg::*;
#(
    parameter int unsigned DEPTH  = LSQ_DEPTH,
    parameter int unsigned ADDR_W = LSQ_ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    lsq_age_tracker_if.slave   bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = ptr_width(DEPTH);

    logic [CNT_W-1:0] head;
    logic [CNT_W-1:0] tail;
    lsq_entry_t       ent [DEPTH];

    logic             result_valid;
    logic [DEPTH-1:0] older_mask;
    logic             older_store_unresolved;
    logic             older_store_match;

    logic [PTR_W-1:0] head_idx;
    logic [PTR_W-1:0] tail_idx;
    logic             empty_c;
    logic             full_c;
    logic             alloc_fire_c;
    logic             commit_fire_c;
    logic             flush_fire_c;
    logic             addr_fire_c;
    logic [PTR_W-1:0] flush_rel_c;
    logic [CNT_W-1:0] flush_tail_c;
    logic [DEPTH-1:0] older_c;
    logic [DEPTH-1:0] squash_c;
    logic [DEPTH-1:0] unres_c;
    logic [DEPTH-1:0] hit_c;

    // Occupancy and request qualification, all from start-of-cycle state.
    assign head_idx      = head[PTR_W-1:0];
    assign tail_idx      = tail[PTR_W-1:0];
    assign empty_c       = (head == tail);
    assign full_c        = (head_idx == tail_idx) && (head[PTR_W] != tail[PTR_W]);
    assign alloc_fire_c  = bus.alloc_valid && !full_c && !reset && !bus.flush_valid;
    assign commit_fire_c = bus.commit_valid && !empty_c;
    assign flush_fire_c  = bus.flush_valid && ent[bus.flush_entry].valid;
    assign addr_fire_c   = bus.addr_valid && ent[bus.addr_entry].valid;
    assign flush_rel_c   = bus.flush_entry - head_idx;
    assign flush_tail_c  = head + CNT_W'(flush_rel_c) + CNT_W'(1);

    // Per-slot age, squash and store-hazard terms.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        lsq_age_tracker_age_compare #(.PTR_W(PTR_W)) u_cmp (
            .head_idx    (head_idx),
            .entry_idx   (PTR_W'(g)),
            .query_idx   (bus.query_entry),
            .entry_valid (ent[g].valid),
            .older       (older_c[g])
        );
        assign squash_c[g] = PTR_W'(PTR_W'(g) - head_idx) > flush_rel_c;
        assign unres_c[g]  = older_c[g] && ent[g].is_store && !ent[g].addr_valid;
        assign hit_c[g]    = older_c[g] && ent[g].is_store && ent[g].addr_valid
                             && (ent[g].addr == ent[bus.query_entry].addr);
    end

    // Head advances on commit; tail follows a flush, otherwise an allocation.
    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (commit_fire_c) begin
                head <= head + CNT_W'(1);
            end
            if (flush_fire_c) begin
                tail <= flush_tail_c;
            end else if (alloc_fire_c) begin
                tail <= tail + CNT_W'(1);
            end
        end
    end

    // Entry updates; later statements (commit, squash) override earlier writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_fire_c && (bus.addr_entry == PTR_W'(i))) begin
                    ent[i].addr_valid <= 1'b1;
                    ent[i].addr       <= LSQ_ADDR_W'(bus.addr);
                end
                if (alloc_fire_c && (tail_idx == PTR_W'(i))) begin
                    ent[i].valid      <= 1'b1;
                    ent[i].is_store   <= bus.alloc_is_store;
                    ent[i].addr_valid <= 1'b0;
                end
                if (commit_fire_c && (head_idx == PTR_W'(i))) begin
                    ent[i].valid      <= 1'b0;
                    ent[i].addr_valid <= 1'b0;
                end
                if (flush_fire_c && squash_c[i]) begin
                    ent[i].valid      <= 1'b0;
                    ent[i].addr_valid <= 1'b0;
                end
            end
        end
    end

    // Registered query result; an invalid query entry yields an all-zero answer.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_valid           <= 1'b0;
            older_mask             <= '0;
            older_store_unresolved <= 1'b0;
            older_store_match      <= 1'b0;
        end else begin
            result_valid <= bus.query_valid;
            if (bus.query_valid && ent[bus.query_entry].valid) begin
                older_mask             <= older_c;
                older_store_unresolved <= |unres_c;
                older_store_match      <= ent[bus.query_entry].addr_valid && (|hit_c);
            end else begin
                older_mask             <= '0;
                older_store_unresolved <= 1'b0;
                older_store_match      <= 1'b0;
            end
        end
    end

    // Status is a direct view of the pointer registers.
    assign bus.alloc_ready            = !full_c && !reset;
    assign bus.alloc_entry            = tail_idx;
    assign bus.commit_entry           = head_idx;
    assign bus.count                  = tail - head;
    assign bus.empty                  = empty_c;
    assign bus.result_valid           = result_valid;
    assign bus.older_mask             = older_mask;
    assign bus.older_store_unresolved = older_store_unresolved;
    assign bus.older_store_match      = older_store_match;

endmodule

// File: tb/tb_lsq_age_tracker.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_lsq_age_tracker;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = lsq_age_tracker_pkg::LSQ_ADDR_W;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lsq_age_tracker_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    lsq_age_tracker #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stimulus for one cycle and the state expected right after its clock edge.
    typedef struct {
        bit          rst, av, st, aw;
        int          ae;
        logic [31:0] ad;
        bit          cm, fl;
        int          fe;
        bit          qv;
        int          qe;
        int          cnt;
        bit          rdy;
        int          ti, hi;
        bit          rv;
        int          mask;
        bit          un, mt;
    } vec_t;

    typedef struct {
        bit          st;
        bit          av;
        logic [31:0] addr;
    } ment_t;

    vec_t        tbl[$];
    ment_t       mq[$];
    int unsigned mhead;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic vec_t mk(bit rst, bit av, bit st, bit aw, int ae, logic [31:0] ad,
                                bit cm, bit fl, int fe, bit qv, int qe,
                                int cnt, bit rdy, int ti, int hi, bit rv, int mask, bit un, bit mt);
        vec_t v;
        v.rst = rst; v.av = av; v.st = st; v.aw = aw; v.ae = ae; v.ad = ad;
        v.cm = cm; v.fl = fl; v.fe = fe; v.qv = qv; v.qe = qe;
        v.cnt = cnt; v.rdy = rdy; v.ti = ti; v.hi = hi;
        v.rv = rv; v.mask = mask; v.un = un; v.mt = mt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset              = v.rst;
        bus.alloc_valid    = v.av;
        bus.alloc_is_store = v.st;
        bus.addr_valid     = v.aw;
        bus.addr_entry     = 3'(v.ae);
        bus.addr           = v.ad;
        bus.commit_valid   = v.cm;
        bus.flush_valid    = v.fl;
        bus.flush_entry    = 3'(v.fe);
        bus.query_valid    = v.qv;
        bus.query_entry    = 3'(v.qe);
    endtask

    task automatic chk(input int n, input string nm, input int act, input int exp);
        if (act != exp) begin
            $display("FAIL vec %0d %s: got 0x%0h expected 0x%0h", n, nm, act, exp);
            n_err++;
        end
    endtask

    task automatic check_vec(input vec_t v, input int n);
        n_vec++;
        chk(n, "count", int'(bus.count), v.cnt);
        chk(n, "empty", int'(bus.empty), int'(v.cnt == 0));
        chk(n, "alloc_ready", int'(bus.alloc_ready), int'(v.rdy));
        chk(n, "alloc_entry", int'(bus.alloc_entry), v.ti);
        chk(n, "commit_entry", int'(bus.commit_entry), v.hi);
        chk(n, "result_valid", int'(bus.result_valid), int'(v.rv));
        if (v.rv) begin
            chk(n, "older_mask", int'(bus.older_mask), v.mask);
            chk(n, "unresolved", int'(bus.older_store_unresolved), int'(v.un));
            chk(n, "match", int'(bus.older_store_match), int'(v.mt));
        end
    endtask

    // Position of entry index e in the age-ordered model queue, or -1.
    function automatic int find_pos(input int e);
        for (int k = 0; k < mq.size(); k++) begin
            if (int'((mhead + k) % DEPTH) == e) return k;
        end
        return -1;
    endfunction

    // Reference model: entries kept oldest-first; index derived from absolute head.
    task automatic model_step(input vec_t vi, output vec_t vo);
        int    p;
        bit    ready;
        bit    was_empty;
        ment_t t;
        vo      = vi;
        vo.rv   = 1'b0;
        vo.mask = 0;
        vo.un   = 1'b0;
        vo.mt   = 1'b0;
        if (vi.rst) begin
            mq.delete();
            mhead = 0;
        end else begin
            vo.rv = vi.qv;
            if (vi.qv) begin
                p = find_pos(vi.qe);
                if (p >= 0) begin
                    for (int k = 0; k < p; k++) begin
                        vo.mask |= 1 << ((mhead + k) % DEPTH);
                        if (mq[k].st) begin
                            if (!mq[k].av) vo.un = 1'b1;
                            else if (mq[p].av && mq[k].addr == mq[p].addr) vo.mt = 1'b1;
                        end
                    end
                end
            end
            ready     = mq.size() < DEPTH;
            was_empty = mq.size() == 0;
            if (vi.aw) begin
                p = find_pos(vi.ae);
                if (p >= 0) begin
                    t = mq[p]; t.av = 1'b1; t.addr = vi.ad; mq[p] = t;
                end
            end
            if (vi.fl) begin
                p = find_pos(vi.fe);
                if (p >= 0) begin
                    while (mq.size() > p + 1) void'(mq.pop_back());
                end
            end else if (vi.av && ready) begin
                t.st = vi.st; t.av = 1'b0; t.addr = '0;
                mq.push_back(t);
            end
            if (vi.cm && !was_empty) begin
                void'(mq.pop_front());
                mhead++;
            end
        end
        vo.cnt = mq.size();
        vo.rdy = (mq.size() < DEPTH) && !vi.rst;
        vo.ti  = int'((mhead + mq.size()) % DEPTH);
        vo.hi  = int'(mhead % DEPTH);
    endtask

    initial begin
        vec_t r;
        vec_t e;

        // rst av st aw ae ad cm fl fe qv qe | cnt rdy ti hi rv mask un mt
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 1,1,1,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,0,0,0,0,0,0, 2,1,2,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,0,0,0,0,0,0, 3,1,3,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 4,1,4,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,1,32'h100,0,0,0,0,0, 4,1,4,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,3,32'h100,0,0,0,0,0, 4,1,4,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,3, 4,1,4,0,1,'h07,1,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 4,1,4,0,1,'h00,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,2, 4,1,4,0,1,'h03,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,5, 4,1,4,0,1,'h00,0,0));
        tbl.push_back(mk(0,0,0,1,2,32'h100,0,0,0,1,3, 4,1,4,0,1,'h07,1,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,3, 4,1,4,0,1,'h07,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 4,1,4,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 5,1,5,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 6,1,6,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 7,1,7,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 8,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,1,0,0,0,0, 7,1,0,1,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,0,0,0,0,0,0, 8,0,1,1,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 8,0,1,1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,1,3, 0,0,0,0,0,0,0,0));
        // walk head to 6, then entries 6,7,0(S),1
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 1,1,1,0,0,0,0,0));
        for (int k = 1; k <= 5; k++) begin
            tbl.push_back(mk(0,1,0,0,0,0,1,0,0,0,0, 1,1,k+1,k,0,0,0,0));
        end
        tbl.push_back(mk(0,0,0,0,0,0,1,0,0,0,0, 0,1,6,6,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 1,1,7,6,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 2,1,0,6,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,0,0,0,0,0,0, 3,1,1,6,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 4,1,2,6,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,1, 4,1,2,6,1,'hC1,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 5,1,3,6,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 6,1,4,6,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,1,1,0,0, 4,1,2,6,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,2, 4,1,2,6,1,'h00,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 4,1,2,6,1,'hC0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,4,0,0, 4,1,2,6,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,1,6,0,0, 0,1,7,7,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,0,0,0,0, 0,1,7,7,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,7, 0,1,7,7,1,'h00,0,0));

        drive(tbl[0]);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_vec(tbl[i], i);
        end

        // Randomized traffic, model kept in lockstep from a reset.
        r = mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        for (int i = 0; i < 3000; i++) begin
            if (i >= 2) begin
                r.rst = ($urandom_range(0, 199) == 0);
                r.av  = ($urandom_range(0, 99) < 60);
                r.st  = $urandom_range(0, 1) == 1;
                r.aw  = ($urandom_range(0, 99) < 40);
                r.ae  = $urandom_range(0, DEPTH - 1);
                r.ad  = 32'($urandom_range(1, 3)) << 8;
                r.cm  = ($urandom_range(0, 99) < 35);
                r.fl  = ($urandom_range(0, 99) < 6);
                r.fe  = $urandom_range(0, DEPTH - 1);
                r.qv  = ($urandom_range(0, 99) < 50);
                r.qe  = $urandom_range(0, DEPTH - 1);
            end
            model_step(r, e);
            drive(r);
            @(posedge clk);
            #1;
            check_vec(e, tbl.size() + i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsq_age_tracker.md
Name: lsq_age_tracker

Overview:
Parametrised, clocked load/store ordering queue for the memory pipeline. Allocates age-ordered entries at a tail pointer, retires at a head pointer, records resolved store addresses, and answers registered "older-store" queries for a given load entry. Uses wrap-bit pointers, so full and empty are unambiguous and a query is correct for any head position, including wrap-around. Supports partial squash of younger entries on flush.

Parameters:
DEPTH, 32, number of entries; power of two, at least 4
PTR_W, log2(DEPTH), entry index width
ADDR_W, 32, stored address width; compared as a full word

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
alloc_valid  in  1  request to allocate one entry at the tail
alloc_is_store  in  1  1 = store, 0 = load
alloc_ready  out  1  queue not full and not in reset
alloc_entry  out  PTR_W  tail index given to the allocation this cycle
addr_valid  in  1  address-resolution write
addr_entry  in  PTR_W  entry being resolved
addr  in  ADDR_W  resolved address
commit_valid  in  1  retire the head entry
commit_entry  out  PTR_W  current head index
flush_valid  in  1  squash every entry younger than flush_entry
flush_entry  in  PTR_W  youngest surviving entry
query_valid  in  1  start an age query
query_entry  in  PTR_W  load entry to check
result_valid  out  1  query result is valid this cycle
older_mask  out  DEPTH  bit e = 1 when valid entry e is older than query_entry
older_store_unresolved  out  1  an older store has no address yet
older_store_match  out  1  an older resolved store address equals the query entry's address
count  out  PTR_W+1  number of occupied entries
empty  out  1  count == 0

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is synchronous and active-high.
- Reset values: head=0, tail=0 (both PTR_W+1 bits, including the wrap bit), all entry valid/addr_valid=0, result_valid=0, older_mask=0, both flags=0, count=0, empty=1. alloc_ready=0 while reset is high.
- Occupancy:
  - empty when head==tail.
  - full when the indices are equal and the wrap bits differ.
  - count = tail-head, computed modulo 2^(PTR_W+1).
- Allocation is accepted when alloc_valid && alloc_ready && !flush_valid. The accepting cycle sets valid, is_store and addr_valid=0, and increments tail.
- alloc_ready depends on state at the start of the cycle only. A commit in the same cycle does not free space for that cycle's allocation.
- Commit: when commit_valid && !empty, clears the head entry and increments head. Commit while empty is ignored.
- Address write: sets addr and addr_valid on a valid entry. A write to an invalid entry is ignored.
- Age rule: with rel(x) = (x - head_idx) mod DEPTH, entry e is older than q iff e is valid and rel(e) < rel(q).
- Flush:
  - When flush_entry is valid, new tail = head + rel(flush_entry) + 1, computed at full width.
  - Entries in (flush_entry, old tail) are invalidated.
  - A flush_entry that is not valid is ignored.
  - Flush beats a same-cycle allocation.
  - A same-cycle commit is still applied. If flush_entry == head, the queue becomes empty.
- Query timing:
  - One-cycle latency. State is sampled at the start of the query cycle; results are registered and presented with result_valid the next cycle.
  - Same-cycle alloc, addr, commit and flush updates are not visible to that query.
  - result_valid is high for exactly one cycle per query_valid.
  - Back-to-back queries are supported, one result per cycle.
- Query result content:
  - If query_entry is invalid: result_valid=1 with mask and flags all 0.
  - older_store_match requires the query entry's own addr_valid=1; otherwise it is 0.
- Reset mid-operation: discards all entries and clears any pending result the following cycle.

Decomposition:
- Shared package/include: DEPTH, PTR_W, ADDR_W defaults; the entry record (valid, is_store, addr_valid, addr); the pointer width PTR_W+1.
- One sub-module: age_compare (inputs: head index, entry index, query index, entry valid; output: older). It is combinational and instantiated DEPTH times to build older_mask.

Test Plan:
- DEPTH=8, reset, allocate L,S,S,L (entries 0-3), resolve S1=0x100 and L3=0x100, leave S2 unresolved, query 3 -> next cycle older_mask=0x07, unresolved=1, match=1.
- Allocate 8 entries -> alloc_ready=0, count=8. Assert commit and alloc together -> alloc dropped, count=7, then the next alloc is accepted into entry 0 with wrap bit set.
- Wrap-around: head=6, entries 6,7,0,1 valid (0 is a store), query 1 -> older_mask=0xC1, store 0 is counted as older.
- Flush with flush_entry=1 while entries 6..3 are valid -> tail index=2, entries 2,3 invalid, count=4. A same-cycle alloc is dropped.
- Query an invalid entry -> result_valid=1, mask=0, flags=0. Query and addr write to entry 2 in the same cycle -> result reflects the pre-write state.
- Assert reset while a query is pending and the queue is full -> next cycle result_valid=0, empty=1, count=0.
